// File: rtl/io_port_ctrl.sv
// I/O-side companion of the 8-bit pipelined CPU: RX FIFO feeding input_port,
// TX FIFO draining OUT bytes, and the interrupt request handshake FSM.
module io_port_ctrl #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             intr_en,
   output logic [7:0]       cpu_input_port,
   input  logic             cpu_in_ack,
   input  logic [7:0]       cpu_out_data,
   input  logic             cpu_out_we,
   output logic             cpu_interrupt,
   input  logic             cpu_intr_ack,
   input  logic             cpu_intr_ret,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [PTR_W:0]   rx_count,
   output logic             out_overflow,
   output logic             in_underflow
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [7:0]     rx_mem_q [DEPTH];
   logic [7:0]     tx_mem_q [DEPTH];
   logic [PTR_W-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [PTR_W-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [PTR_W:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic           ovf_q, ovf_d, unf_q, unf_d;
   state_t         state_q, state_d;

   logic rx_full, rx_empty, tx_full, tx_empty;
   logic rx_push, rx_pop, tx_push, tx_pop;

   assign rx_full  = (rx_cnt_q == FULL_CNT);
   assign rx_empty = (rx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == FULL_CNT);
   assign tx_empty = (tx_cnt_q == '0);

   assign rx_push = rx_valid && !rx_full;
   assign rx_pop  = cpu_in_ack && !rx_empty;
   // Full is judged on registered state, so a same-cycle pop never rescues an OUT byte.
   assign tx_push = cpu_out_we && !tx_full;
   assign tx_pop  = tx_ready && !tx_empty;

   assign rx_ready       = !rx_full;
   assign tx_valid       = !tx_empty;
   assign cpu_input_port = rx_empty ? '0 : rx_mem_q[rx_rd_q];
   assign tx_data        = tx_empty ? '0 : tx_mem_q[tx_rd_q];
   assign rx_count       = rx_cnt_q;
   assign out_overflow   = ovf_q;
   assign in_underflow   = unf_q;

   always_comb begin
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      rx_cnt_d = rx_cnt_q;
      tx_wr_d  = tx_wr_q;
      tx_rd_d  = tx_rd_q;
      tx_cnt_d = tx_cnt_q;
      ovf_d    = ovf_q || (cpu_out_we && tx_full);
      unf_d    = unf_q || (cpu_in_ack && rx_empty);

      if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
      case ({rx_push, rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
         2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
         default: rx_cnt_d = rx_cnt_q;
      endcase

      if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
      case ({tx_push, tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
         2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
         default: tx_cnt_d = tx_cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         rx_cnt_q <= rx_cnt_d;
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         tx_cnt_q <= tx_cnt_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage needs no reset: reads are masked to zero while a FIFO is empty.
   always_ff @(posedge clk) begin
      if (reset && rx_push) rx_mem_q[rx_wr_q] <= rx_data;
      if (reset && tx_push) tx_mem_q[tx_wr_q] <= cpu_out_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      cpu_interrupt = 1'b0;
      case (state_q)
         IDLE: begin
            if (intr_en && !rx_empty) state_d = REQ;
         end
         REQ: begin
            cpu_interrupt = 1'b1;
            if (cpu_intr_ack)  state_d = SERVICE;
            else if (!intr_en) state_d = IDLE;
         end
         SERVICE: begin
            if (cpu_intr_ret) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_io_port_ctrl;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             intr_en;
   logic [7:0]       cpu_input_port;
   logic             cpu_in_ack;
   logic [7:0]       cpu_out_data;
   logic             cpu_out_we;
   logic             cpu_interrupt;
   logic             cpu_intr_ack;
   logic             cpu_intr_ret;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [PTR_W:0]   rx_count;
   logic             out_overflow;
   logic             in_underflow;

   io_port_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .intr_en        (intr_en),
      .cpu_input_port (cpu_input_port),
      .cpu_in_ack     (cpu_in_ack),
      .cpu_out_data   (cpu_out_data),
      .cpu_out_we     (cpu_out_we),
      .cpu_interrupt  (cpu_interrupt),
      .cpu_intr_ack   (cpu_intr_ack),
      .cpu_intr_ret   (cpu_intr_ret),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_count       (rx_count),
      .out_overflow   (out_overflow),
      .in_underflow   (in_underflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   bit m_req, m_srv, m_ovf, m_unf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic model_step();
      bit rx_was_empty, tx_was_full, rx_was_full, tx_was_empty;
      if (!reset) begin
         rxq.delete();
         txq.delete();
         m_req = 0; m_srv = 0; m_ovf = 0; m_unf = 0;
         return;
      end
      rx_was_empty = (rxq.size() == 0);
      rx_was_full  = (rxq.size() == DEPTH);
      tx_was_empty = (txq.size() == 0);
      tx_was_full  = (txq.size() == DEPTH);

      if (cpu_in_ack && rx_was_empty) m_unf = 1;
      if (cpu_out_we && tx_was_full)  m_ovf = 1;
      if (cpu_in_ack && !rx_was_empty) void'(rxq.pop_front());
      if (rx_valid && !rx_was_full)    rxq.push_back(rx_data);
      if (tx_ready && !tx_was_empty)   void'(txq.pop_front());
      if (cpu_out_we && !tx_was_full)  txq.push_back(cpu_out_data);

      if (m_srv) begin
         if (cpu_intr_ret) m_srv = 0;
      end else if (m_req) begin
         if (cpu_intr_ack) begin
            m_req = 0;
            m_srv = 1;
         end else if (!intr_en) m_req = 0;
      end else if (intr_en && !rx_was_empty) m_req = 1;
   endtask

   task automatic check_all();
      check("cpu_input_port", cpu_input_port, (rxq.size() == 0) ? 8'h00 : rxq[0]);
      check("rx_count", rx_count, rxq.size());
      check("rx_ready", rx_ready, rxq.size() != DEPTH);
      check("tx_valid", tx_valid, txq.size() != 0);
      check("tx_data", tx_data, (txq.size() == 0) ? 8'h00 : txq[0]);
      check("cpu_interrupt", cpu_interrupt, m_req);
      check("out_overflow", out_overflow, m_ovf);
      check("in_underflow", in_underflow, m_unf);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic clear_pulses();
      cpu_in_ack   = 0;
      cpu_out_we   = 0;
      cpu_intr_ack = 0;
      cpu_intr_ret = 0;
      rx_valid     = 0;
      tx_ready     = 0;
   endtask

   task automatic do_reset();
      clear_pulses();
      reset = 0;
      tick();
      reset = 1;
   endtask

   initial begin
      reset = 0; intr_en = 0; rx_data = 0; cpu_out_data = 0;
      clear_pulses();
      @(negedge clk);
      do_reset();
      check("reset_rx_ready", rx_ready, 1);
      check("reset_port", cpu_input_port, 8'h00);

      // RX byte raises an interrupt, service it, drain it, return.
      intr_en = 1;
      rx_data = 8'hA5; rx_valid = 1; tick();
      check("t1_port", cpu_input_port, 8'hA5);
      check("t1_count", rx_count, 1);
      rx_valid = 0; tick();
      check("t1_intr", cpu_interrupt, 1);
      cpu_intr_ack = 1; tick(); cpu_intr_ack = 0;
      check("t2_intr_ack", cpu_interrupt, 0);
      cpu_in_ack = 1; tick(); cpu_in_ack = 0;
      check("t2_port", cpu_input_port, 8'h00);
      cpu_intr_ret = 1; tick(); cpu_intr_ret = 0;
      tick(); tick();
      check("t2_intr_idle", cpu_interrupt, 0);

      // RX fill past depth with pointer wrap.
      intr_en = 0;
      for (int i = 1; i <= 4; i++) begin
         rx_data = 8'(i); rx_valid = 1; tick();
      end
      check("t3_not_ready", rx_ready, 0);
      rx_data = 8'h05; tick();
      cpu_in_ack = 1; tick(); cpu_in_ack = 0;
      tick();
      rx_valid = 0;
      check("t3_count", rx_count, 4);
      for (int i = 2; i <= 5; i++) begin
         check("t3_pop", cpu_input_port, 32'(i));
         cpu_in_ack = 1; tick(); cpu_in_ack = 0;
      end
      check("t3_empty", rx_count, 0);

      // TX overflow then drain.
      tx_ready = 0;
      for (int i = 1; i <= 5; i++) begin
         cpu_out_data = 8'(i * 16); cpu_out_we = 1; tick();
      end
      cpu_out_we = 0;
      check("t4_tx_data", tx_data, 8'h10);
      check("t4_ovf", out_overflow, 1);
      tx_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         check("t4_drain", tx_data, 32'(i * 16));
         tick();
      end
      check("t4_tx_valid", tx_valid, 0);

      // Simultaneous TX push and pop with one entry.
      tx_ready = 0; cpu_out_data = 8'h11; cpu_out_we = 1; tick();
      cpu_out_data = 8'h77; tx_ready = 1; tick();
      cpu_out_we = 0; tx_ready = 0;
      check("t5_valid", tx_valid, 1);
      check("t5_data", tx_data, 8'h77);

      // Reset while requesting with both FIFOs at two entries.
      cpu_out_data = 8'h22; cpu_out_we = 1; tick(); cpu_out_we = 0;
      intr_en = 1;
      rx_data = 8'h31; rx_valid = 1; tick();
      rx_data = 8'h32; tick(); rx_valid = 0;
      tick();
      check("t6_req", cpu_interrupt, 1);
      do_reset();
      check("t6_count", rx_count, 0);
      check("t6_intr", cpu_interrupt, 0);
      check("t6_ovf", out_overflow, 0);
      check("t6_txv", tx_valid, 0);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         reset        = ($urandom_range(0, 199) != 0);
         intr_en      = ($urandom_range(0, 7) != 0);
         rx_valid     = $urandom_range(0, 1);
         rx_data      = 8'($urandom);
         cpu_in_ack   = ($urandom_range(0, 2) == 0);
         cpu_out_we   = ($urandom_range(0, 2) == 0);
         cpu_out_data = 8'($urandom);
         tx_ready     = $urandom_range(0, 1);
         cpu_intr_ack = ($urandom_range(0, 3) == 0);
         cpu_intr_ret = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
